// File: rtl/ocp_arb2_if.sv
// ocp_arb2_if: one OCP point-to-point link (request + accept + response).
// The arbiter uses the slave modport toward each master and the master modport toward the peripheral.
interface ocp_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            cmd;
    logic [DATA_WIDTH-1:0] data;
    logic [BEN_WIDTH-1:0]  byte_en;
    logic                  cmd_accept;
    logic [DATA_WIDTH-1:0] sdata;
    logic [1:0]            sresp;

    modport master (
        output addr, cmd, data, byte_en,
        input  cmd_accept, sdata, sresp
    );

    modport slave (
        input  addr, cmd, data, byte_en,
        output cmd_accept, sdata, sresp
    );
endinterface

// File: rtl/ocp_arb2.sv
// ocp_arb2: two-master round-robin OCP arbiter sharing one slave; grant held through accept and read response.
// Optional read-response timeout (TIMEOUT cycles) is enabled by defining OCP_ARB2_RESP_TIMEOUT_EN.
module ocp_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       nrst,
    ocp_arb2_if.slave  m0,
    ocp_arb2_if.slave  m1,
    ocp_arb2_if.master s
);
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RESP} state_t;

    state_t state_reg;
    logic   grant_reg;
    logic   last_reg;

    logic [1:0][2:0]            req_cmd;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_data;
    logic [1:0][BEN_WIDTH-1:0]  req_ben;
    logic [1:0]                 req;

    logic [1:0]                 acc_out;
    logic [1:0][1:0]            sresp_out;
    logic [1:0][DATA_WIDTH-1:0] sdata_out;

    logic                  in_cmd;
    logic                  in_resp;
    logic                  timeout_hit;
    logic [2:0]            g_cmd;
    logic [1:0]            route_resp;
    logic [DATA_WIDTH-1:0] route_data;

    assign req_cmd  = {m1.cmd, m0.cmd};
    assign req_addr = {m1.addr, m0.addr};
    assign req_data = {m1.data, m0.data};
    assign req_ben  = {m1.byte_en, m0.byte_en};
    assign req      = {m1.cmd != CMD_IDLE, m0.cmd != CMD_IDLE};

    // Gating with nrst keeps every output at its idle value while reset is held.
    assign in_cmd  = nrst && (state_reg == ST_CMD);
    assign in_resp = nrst && (state_reg == ST_RESP);
    assign g_cmd   = req_cmd[grant_reg];

`ifdef OCP_ARB2_RESP_TIMEOUT_EN
    logic [15:0] tcnt_reg;

    assign timeout_hit = in_resp && (s.sresp == RESP_NULL) && (tcnt_reg == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!nrst || state_reg != ST_RESP) begin
            tcnt_reg <= '0;
        end else if (s.sresp == RESP_NULL) begin
            tcnt_reg <= tcnt_reg + 16'd1;
        end
    end
`else
    // RESP waits indefinitely; TIMEOUT is always positive so this is constant zero.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    assign route_resp = timeout_hit ? RESP_ERR : s.sresp;
    assign route_data = timeout_hit ? '0 : s.sdata;

    assign s.cmd     = in_cmd ? g_cmd : CMD_IDLE;
    assign s.addr    = in_cmd ? req_addr[grant_reg] : '0;
    assign s.data    = in_cmd ? req_data[grant_reg] : '0;
    assign s.byte_en = in_cmd ? req_ben[grant_reg] : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            logic sel;
            assign sel            = (in_cmd || in_resp) && (grant_reg == 1'(gi));
            assign acc_out[gi]    = sel && in_cmd && s.cmd_accept;
            assign sresp_out[gi]  = sel ? route_resp : RESP_NULL;
            assign sdata_out[gi]  = sel ? route_data : '0;
        end
    endgenerate

    assign m0.cmd_accept = acc_out[0];
    assign m0.sresp      = sresp_out[0];
    assign m0.sdata      = sdata_out[0];
    assign m1.cmd_accept = acc_out[1];
    assign m1.sresp      = sresp_out[1];
    assign m1.sdata      = sdata_out[1];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
            grant_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant_reg <= (req == 2'b11) ? ~last_reg : req[1];
                        state_reg <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // A master withdrawing its command abandons the slot without counting as served.
                    if (g_cmd == CMD_IDLE) begin
                        state_reg <= ST_IDLE;
                    end else if (s.cmd_accept) begin
                        if (g_cmd != CMD_READ || s.sresp != RESP_NULL) begin
                            state_reg <= ST_IDLE;
                            last_reg  <= grant_reg;
                        end else begin
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (s.sresp != RESP_NULL || timeout_hit) begin
                        state_reg <= ST_IDLE;
                        last_reg  <= grant_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule
